// File: rtl/ks_sum_stage.sv
// ---------------------------------------------------------------------------
// ks_sum_stage
//
// Final post-processing stage of a Kogge-Stone adder. The stage takes the
// prefix-tree outputs G(i:0) / P(i:0), the bitwise propagates and the
// carry-in. It forms the carries, sum, carry-out, signed overflow and zero
// flags, then registers the result behind a valid/ready handshake that uses a
// 2-entry skid buffer (main register M plus skid register S).
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      upstream presents a valid prefix word
//   in_ready   out  1      stage can accept a word this cycle (from a flop)
//   g_prefix   in   WIDTH  g_prefix[i] = G(i:0)
//   p_prefix   in   WIDTH  p_prefix[i] = P(i:0)
//   p_bit      in   WIDTH  p_bit[i] = a[i]^b[i]
//   cin        in   1      carry-in
//   out_valid  out  1      sum/flags valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  a+b+cin, low WIDTH bits
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      two's-complement overflow
//   zero       out  1      sum == 0
// ---------------------------------------------------------------------------
module ks_sum_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_prefix,
    input  logic [WIDTH-1:0] p_prefix,
    input  logic [WIDTH-1:0] p_bit,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Stored word layout: {sum, cout, ovf, zero}
    localparam int DW = WIDTH + 3;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic [DW-1:0]    in_word;

    logic [DW-1:0]    m_word;
    logic             m_valid;
    logic [DW-1:0]    s_word;
    logic             s_valid;

    logic             in_xfer;
    logic             out_xfer;

    // Carry into bit i: the group (i-1:0) either generates a carry, or it
    // propagates the external carry-in through every bit.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 1; i <= WIDTH; i++) begin
            carry[i] = g_prefix[i-1] | (p_prefix[i-1] & cin);
        end
    end

    assign sum_comb = p_bit ^ carry[WIDTH-1:0];

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign in_word = {sum_comb,
                      carry[WIDTH],
                      carry[WIDTH] ^ carry[WIDTH-1],
                      ~|sum_comb};

    // in_ready comes straight from the skid-valid flop so that out_ready never
    // reaches the upstream ready combinationally.
    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = m_valid & out_ready;

    assign {sum, cout, ovf, zero} = m_word;

    // Skid-buffer update. M is the presented word; S only fills when M is
    // stalled and a new word still arrives. When M drains, S refills it first
    // so that ordering is preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_word  <= '0;
            m_valid <= 1'b0;
            s_word  <= '0;
            s_valid <= 1'b0;
        end else if (out_xfer) begin
            if (s_valid) begin
                m_word <= s_word;
                if (in_xfer) begin
                    s_word <= in_word;
                end else begin
                    s_valid <= 1'b0;
                end
            end else if (in_xfer) begin
                m_word <= in_word;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (m_valid) begin
                s_word  <= in_word;
                s_valid <= 1'b1;
            end else begin
                m_word  <= in_word;
                m_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ks_sum_stage.sv
// ---------------------------------------------------------------------------
// tb_ks_sum_stage
//
// Testbench for ks_sum_stage (WIDTH=16). Operands a, b, cin are turned into
// prefix-tree inputs with plain arithmetic, and the expected
// {sum,cout,ovf,zero} is taken from a+b+cin. Accepted words are queued and a
// monitor compares every presented output against the queue head, popping on
// each output transfer.
// ---------------------------------------------------------------------------
module tb_ks_sum_stage;

    localparam int  WIDTH      = 16;
    localparam time CLK_PERIOD = 10;

    typedef logic [WIDTH+2:0] word_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             cin       = 1'b0;
    logic [WIDTH-1:0] g_prefix  = '0;
    logic [WIDTH-1:0] p_prefix  = '0;
    logic [WIDTH-1:0] p_bit     = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    word_t exp_q[$];
    int    total_checks  = 0;
    int    passed_checks = 0;
    int    pop_count     = 0;

    ks_sum_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_prefix  (g_prefix),
        .p_prefix  (p_prefix),
        .p_bit     (p_bit),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #(CLK_PERIOD/2) clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // G(i:0) is the carry out of the low i+1 bits with no carry-in;
    // P(i:0) says every bit from i down to 0 propagates.
    function automatic void buildPrefix(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        output logic [WIDTH-1:0] g,
                                        output logic [WIDTH-1:0] p,
                                        output logic [WIDTH-1:0] pb);
        int unsigned mask;
        int unsigned t;
        pb = a ^ b;
        for (int i = 0; i < WIDTH; i++) begin
            mask = (32'd1 << (i + 1)) - 32'd1;
            t    = (32'(a) & mask) + (32'(b) & mask);
            g[i] = t[i+1];
            p[i] = ((32'(pb) & mask) == mask);
        end
    endfunction

    function automatic word_t refResult(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic ci);
        int unsigned      t;
        logic [WIDTH-1:0] s;
        logic             ov;
        t  = 32'(a) + 32'(b) + 32'(ci);
        s  = t[WIDTH-1:0];
        ov = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        return {s, t[WIDTH], ov, (s == '0)};
    endfunction

    // Drive one cycle of inputs just after a rising edge; report whether the
    // word will be taken at the next edge and queue its expected result.
    task automatic applyStimulus(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic ci, input logic vld,
                                 input logic rdy, output logic accepted);
        logic [WIDTH-1:0] g, p, pb;
        @(posedge clk);
        #1;
        buildPrefix(a, b, g, p, pb);
        g_prefix  = g;
        p_prefix  = p;
        p_bit     = pb;
        cin       = ci;
        in_valid  = vld;
        out_ready = rdy;
        #1;
        accepted = vld && in_ready;
        if (accepted) exp_q.push_back(refResult(a, b, ci));
    endtask

    task automatic idleCycle(input logic rdy);
        logic acc;
        applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, rdy, acc);
    endtask

    task automatic runDirected(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic ci,
                               input logic [WIDTH-1:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf,
                               input logic exp_zero);
        logic acc;
        applyStimulus(a, b, ci, 1'b1, 1'b1, acc);
        checkOutput({name, "_accepted"}, 32'(acc), 32'd1);
        idleCycle(1'b1);
        checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_sum"}, 32'(sum), 32'(exp_sum));
        checkOutput({name, "_cout"}, 32'(cout), 32'(exp_cout));
        checkOutput({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        checkOutput({name, "_zero"}, 32'(zero), 32'(exp_zero));
    endtask

    // Monitor: every presented word must match the oldest expected word; a
    // word is retired only when the downstream takes it.
    always begin
        @(negedge clk);
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                checkOutput("mon_word", 32'({sum, cout, ovf, zero}), 32'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pop_count++;
                end
            end
        end
    end

    initial begin
        #(CLK_PERIOD * 20000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic  acc;
        int    tries;
        int    pop_start;
        int    acc_count;
        word_t w1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_flags", 32'({cout, ovf, zero}), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("first_cycle_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic corners
        runDirected("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        runDirected("overflow", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        runDirected("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        runDirected("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        idleCycle(1'b1);

        // Backpressure: two words fit, the third is refused until drain
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("bp_w1_acc", 32'(acc), 32'd1);
        w1 = refResult(16'h1234, 16'h1111, 1'b0);
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 1'b0, acc);
        checkOutput("bp_w2_acc", 32'(acc), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h00FF, 16'h0F0F, 1'b1, 1'b1, 1'b0, acc);
            checkOutput("bp_w3_refused", 32'(acc), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_word", 32'({sum, cout, ovf, zero}), 32'(w1));
        end
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 10) begin
            applyStimulus(16'h00FF, 16'h0F0F, 1'b1, 1'b1, 1'b1, acc);
            tries++;
        end
        checkOutput("bp_w3_accepted", 32'(acc), 32'd1);
        repeat (4) idleCycle(1'b1);
        checkOutput("bp_drained", 32'(exp_q.size()), 32'd0);

        // Streaming: one word per cycle with no bubbles
        pop_start = pop_count;
        acc_count = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b1, acc);
            if (acc) acc_count++;
        end
        idleCycle(1'b1);
        @(negedge clk);
        #1;
        checkOutput("stream_accepted", 32'(acc_count), 32'd100);
        checkOutput("stream_outputs", 32'(pop_count - pop_start), 32'd100);

        // Random valid/ready mix exercising every skid path
        for (int i = 0; i < 300; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), acc);
        end
        tries = 0;
        while (exp_q.size() != 0 && tries < 10) begin
            idleCycle(1'b1);
            tries++;
        end
        checkOutput("random_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both registers full
        applyStimulus(16'h4321, 16'h0101, 1'b0, 1'b1, 1'b0, acc);
        applyStimulus(16'h8765, 16'h0202, 1'b1, 1'b1, 1'b0, acc);
        applyStimulus(16'hCAFE, 16'h0303, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("full_refuses", 32'(acc), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_sum", 32'(sum), 32'd0);
        checkOutput("midrst_flags", 32'({cout, ovf, zero}), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (4) idleCycle(1'b1);
        applyStimulus(16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1'b1, acc);
        checkOutput("post_rst_accept", 32'(acc), 32'd1);
        repeat (3) idleCycle(1'b1);
        checkOutput("post_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
